// File: rtl/snn_pkg.sv
// Constants and types shared by the SNN layer datapath and the inter-layer spike link.
package snn_pkg;

    localparam int unsigned IO_WIDTH       = 16;
    localparam int unsigned LINK_AW        = 4;
    localparam int unsigned LINK_GAP_WIDTH = 4;

    typedef logic [IO_WIDTH-1:0] spike_w_t;

endpackage

// File: rtl/spike_link_if.sv
// Spike link configuration, upstream word input and paced downstream output/status bundle.
interface spike_link_if #(
    parameter int unsigned IO_WIDTH  = snn_pkg::IO_WIDTH,
    parameter int unsigned AW        = snn_pkg::LINK_AW,
    parameter int unsigned GAP_WIDTH = snn_pkg::LINK_GAP_WIDTH
);

    logic [GAP_WIDTH-1:0] GAP;
    logic                 CLR_OVF;
    logic                 IN_VALID;
    logic [IO_WIDTH-1:0]  IN_SPIKE;
    logic                 OUT_VALID;
    logic [IO_WIDTH-1:0]  OUT_SPIKE;
    logic [AW:0]          LEVEL;
    logic                 FULL;
    logic                 EMPTY;
    logic                 OVF;

    modport master (
        output GAP, CLR_OVF, IN_VALID, IN_SPIKE,
        input  OUT_VALID, OUT_SPIKE, LEVEL, FULL, EMPTY, OVF
    );

    modport slave (
        input  GAP, CLR_OVF, IN_VALID, IN_SPIKE,
        output OUT_VALID, OUT_SPIKE, LEVEL, FULL, EMPTY, OVF
    );

endinterface

// File: rtl/spike_link_mem.sv
// 2^AW x IO_WIDTH register file, one write port and one registered read port.
module spike_link_mem #(
    parameter int unsigned IO_WIDTH = snn_pkg::IO_WIDTH,
    parameter int unsigned AW       = snn_pkg::LINK_AW
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [IO_WIDTH-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [IO_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [IO_WIDTH-1:0] mem_q [DEPTH];
    logic [IO_WIDTH-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees the pre-write contents when raddr == waddr on the same edge.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spike_link.sv
// Elastic FIFO between two layers: accepts words without backpressure, re-issues them paced.
module spike_link #(
    parameter int unsigned IO_WIDTH  = snn_pkg::IO_WIDTH,
    parameter int unsigned AW        = snn_pkg::LINK_AW,
    parameter int unsigned GAP_WIDTH = snn_pkg::LINK_GAP_WIDTH
) (
    input  logic     CLK,
    input  logic     RSTB,
    spike_link_if.slave bus
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [AW-1:0]        wp_q, rp_q;
    logic [AW:0]          level_q, level_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q;
    logic                 full, empty, push, pop, drop;
    logic [IO_WIDTH-1:0]  rdata;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && (gap_q == '0);
    // A pop on the same edge frees a slot, so a word arriving at full is still taken.
    assign push  = bus.IN_VALID && (!full || pop);
    assign drop  = bus.IN_VALID && full && !pop;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end

        gap_d = gap_q;
        if (pop) begin
            gap_d = bus.GAP;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_WIDTH'(1);
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            level_q <= level_d;
            gap_q   <= gap_d;
            ovf_q   <= ovf_d;
            valid_q <= pop;
        end
    end

    // The memory read register doubles as the held OUT_SPIKE register.
    spike_link_mem #(
        .IO_WIDTH (IO_WIDTH),
        .AW       (AW)
    ) u_mem (
        .CLK   (CLK),
        .RSTB  (RSTB),
        .we    (push),
        .waddr (wp_q),
        .wdata (bus.IN_SPIKE),
        .re    (pop),
        .raddr (rp_q),
        .rdata (rdata)
    );

    assign bus.OUT_VALID = valid_q;
    assign bus.OUT_SPIKE = rdata;
    assign bus.LEVEL     = level_q;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_spike_link.sv
// Bench for spike_link: cycle vector tables plus an in-order scoreboard on the output strobes.
module tb_spike_link;
    import snn_pkg::*;

    typedef struct {
        logic [3:0]  gap;
        logic        in_valid;
        logic [15:0] in_spike;
        logic        clr_ovf;
        logic        exp_valid;
        int          exp_level;
        logic        exp_ovf;
    } vec_t;

    logic     clk = 1'b0;
    logic     rstb;
    int       checks = 0;
    int       errors = 0;
    spike_w_t sb [$];
    vec_t     vecs [$];

    spike_link_if bus ();

    spike_link dut (
        .CLK  (clk),
        .RSTB (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] gap, input logic iv, input logic [15:0] sp,
                           input logic clr, input logic ev, input int lvl, input logic eo);
        vec_t v;
        v.gap = gap; v.in_valid = iv; v.in_spike = sp; v.clr_ovf = clr;
        v.exp_valid = ev; v.exp_level = lvl; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bus.GAP      = v.gap;
        bus.IN_VALID = v.in_valid;
        bus.IN_SPIKE = v.in_spike;
        bus.CLR_OVF  = v.clr_ovf;
        if (v.in_valid) sb.push_back(v.in_spike);
        tick();
        check({tag, ".valid"}, 32'(bus.OUT_VALID), 32'(v.exp_valid));
        check({tag, ".level"}, 32'(bus.LEVEL), 32'(v.exp_level));
        check({tag, ".empty"}, 32'(bus.EMPTY), 32'(v.exp_level == 0));
        check({tag, ".full"}, 32'(bus.FULL), 32'(v.exp_level == 16));
        check({tag, ".ovf"}, 32'(bus.OVF), 32'(v.exp_ovf));
        bus.IN_VALID = 1'b0;
        bus.CLR_OVF  = 1'b0;
    endtask

    // Every strobe must match the oldest outstanding accepted word.
    always @(negedge clk) begin
        if (rstb === 1'b1 && bus.OUT_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got strobe 0x%0h, want no strobe", bus.OUT_SPIKE);
            end else begin
                check("sb_spike", 32'(bus.OUT_SPIKE), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        int pace_lvl [19] = '{1, 1, 2, 3, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
        int n;
        vec_t v;

        rstb         = 1'b0;
        bus.GAP      = '0;
        bus.CLR_OVF  = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_SPIKE = '0;
        tick();
        tick();
        check("rst.valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst.spike", 32'(bus.OUT_SPIKE), 32'd0);
        check("rst.level", 32'(bus.LEVEL), 32'd0);
        check("rst.empty", 32'(bus.EMPTY), 32'd1);
        check("rst.full", 32'(bus.FULL), 32'd0);
        check("rst.ovf", 32'(bus.OVF), 32'd0);
        rstb = 1'b1;
        tick();

        // Single word, GAP=0: strobe on the second edge after the word is sampled.
        add_vec(4'd0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1, 1'b0);
        add_vec(4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        add_vec(4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        // Pacing, GAP=3: five words, strobes every 4 cycles, peak level 4.
        for (int i = 0; i < 19; i++) begin
            add_vec(4'd3, i < 5, 16'(i + 1), 1'b0, (i % 4) == 1, pace_lvl[i], 1'b0);
        end
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec[%0d]", i));
        end

        // Fill/overflow, GAP=15: words 1..17 fill, 18 rides a pop, 19 and 20 drop.
        bus.GAP = 4'd15;
        repeat (5) tick();
        for (int i = 0; i < 20; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_SPIKE = 16'h0100 + 16'(i + 1);
            bus.CLR_OVF  = (i == 19);
            if (i < 18) sb.push_back(bus.IN_SPIKE);
            tick();
            if (i == 15) begin
                check("ovf.level15", 32'(bus.LEVEL), 32'd15);
                check("ovf.notfull15", 32'(bus.FULL), 32'd0);
            end
            if (i == 16) begin
                check("ovf.level16", 32'(bus.LEVEL), 32'd16);
                check("ovf.full16", 32'(bus.FULL), 32'd1);
                check("ovf.clean16", 32'(bus.OVF), 32'd0);
            end
            if (i == 17) begin
                check("fullpop.level", 32'(bus.LEVEL), 32'd16);
                check("fullpop.ovf", 32'(bus.OVF), 32'd0);
                check("fullpop.valid", 32'(bus.OUT_VALID), 32'd1);
            end
            if (i >= 18) begin
                check($sformatf("drop[%0d].ovf", i), 32'(bus.OVF), 32'd1);
                check($sformatf("drop[%0d].level", i), 32'(bus.LEVEL), 32'd16);
            end
        end
        bus.IN_VALID = 1'b0;
        bus.CLR_OVF  = 1'b1;
        tick();
        bus.CLR_OVF = 1'b0;
        check("clr.ovf", 32'(bus.OVF), 32'd0);

        n = 0;
        while (n < 400 && !(bus.EMPTY && !bus.OUT_VALID)) begin
            tick();
            n++;
        end
        check("drain.empty", 32'(bus.EMPTY), 32'd1);
        check("drain.sb_left", 32'(sb.size()), 32'd0);

        // Reset mid-drain of 8 words, right while a strobe is high.
        bus.GAP = 4'd3;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_SPIKE = 16'h0200 + 16'(i);
            sb.push_back(bus.IN_SPIKE);
            tick();
        end
        bus.IN_VALID = 1'b0;
        n = 0;
        while (n < 10 && !bus.OUT_VALID) begin
            tick();
            n++;
        end
        check("mid.valid_before", 32'(bus.OUT_VALID), 32'd1);
        #2;
        rstb = 1'b0;
        sb.delete();
        #1;
        check("mid.valid", 32'(bus.OUT_VALID), 32'd0);
        check("mid.level", 32'(bus.LEVEL), 32'd0);
        check("mid.empty", 32'(bus.EMPTY), 32'd1);
        check("mid.spike", 32'(bus.OUT_SPIKE), 32'd0);
        tick();
        tick();
        rstb = 1'b1;
        v = '{gap: 4'd0, in_valid: 1'b1, in_spike: 16'h1234, clr_ovf: 1'b0,
              exp_valid: 1'b0, exp_level: 1, exp_ovf: 1'b0};
        run_vec(v, "post.e0");
        v = '{gap: 4'd0, in_valid: 1'b0, in_spike: 16'h0000, clr_ovf: 1'b0,
              exp_valid: 1'b1, exp_level: 0, exp_ovf: 1'b0};
        run_vec(v, "post.e1");
        v.exp_valid = 1'b0;
        run_vec(v, "post.e2");
        check("post.sb_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
